dm_bytelane: RTL and testbench

Parametrised data memory for the pipelined MIPS core, successor to the word-only DM. Adds byte/halfword stores with lane enables, sign/zero-extended loads, alignment and range fault detection with a sticky fault record, and a hardware clear sequence after reset. Sits in the MEM stage and is driven by the ALU result (address), rt data (store data) and decoded memory op.

---
 rtl/dm_bytelane.sv | 190 +++++++++++++++++++
 tb/tb_dm_bytelane.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_bytelane.sv
// dm_bytelane: data memory for the MEM stage of the pipelined MIPS core.
// It supports byte, halfword and word stores with little-endian lane
// enables. Loads are combinational and sign- or zero-extended.
// Misaligned, out-of-range and illegal-op accesses raise a fault, and the
// first fault address since reset is kept in a sticky record.
// After reset the memory clears itself one word per clock edge.
// Optional feature macro: DM_BYTELANE_TRACE_EN prints one line per
// committed store and one line per faulting edge.
module dm_bytelane #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [2:0]        op,
    input  logic [31:0]       pc,
    output logic [31:0]       rd,
    output logic              busy,
    output logic              fault,
    output logic              fault_valid,
    output logic [ADDR_W-1:0] fault_addr
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_HS = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_BS = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [DEPTH_LOG2-1:0]   init_ptr_reg;
    logic                    busy_reg;
    logic                    fault_valid_reg;
    logic [ADDR_W-1:0]       fault_addr_reg;

    logic [31:0]             mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    in_range;
    logic                    is_word;
    logic                    is_half;
    logic                    is_byte;
    logic                    op_illegal;
    logic                    misaligned;
    logic                    access_bad;
    logic                    commit;
    logic [31:0]             old_word;
    logic [3:0]              be;
    logic [31:0]             wd_lanes;
    logic [31:0]             merged_word;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [31:0]             load_data;

    // Address and op decode for the current access.
    assign word_idx   = addr[DEPTH_LOG2+1:2];
    assign in_range   = (addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
    assign is_word    = (op == OP_W);
    assign is_half    = (op == OP_HS) || (op == OP_HU);
    assign is_byte    = (op == OP_BS) || (op == OP_BU);
    assign op_illegal = !(is_word || is_half || is_byte);
    assign misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    assign access_bad = op_illegal || misaligned || !in_range;

    assign fault  = (mem_write || mem_read) && !busy_reg && access_bad;
    assign commit = mem_write && !busy_reg && !access_bad;

    // The read is asynchronous because the load result must appear in the same cycle.
    assign old_word = mem[word_idx];

    // Lane enables, with the store data replicated onto every lane it could target.
    always_comb begin
        be       = 4'b0000;
        wd_lanes = wd;
        if (is_byte) begin
            be       = 4'b0001 << addr[1:0];
            wd_lanes = {4{wd[7:0]}};
        end else if (is_half) begin
            be       = addr[1] ? 4'b1100 : 4'b0011;
            wd_lanes = {2{wd[15:0]}};
        end else if (is_word) begin
            be       = 4'b1111;
        end
    end

    // Per-byte merge of the new lanes over the current word contents.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = be[gi] ? wd_lanes[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

    // Lane extraction plus sign or zero extension for loads.
    always_comb begin
        byte_sel = 8'h00;
        case (addr[1:0])
            2'd0: byte_sel = old_word[7:0];
            2'd1: byte_sel = old_word[15:8];
            2'd2: byte_sel = old_word[23:16];
            default: byte_sel = old_word[31:24];
        endcase
        half_sel = addr[1] ? old_word[31:16] : old_word[15:0];
        case (op)
            OP_W:    load_data = old_word;
            OP_HS:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_HU:   load_data = {16'h0000, half_sel};
            OP_BS:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   load_data = {24'h000000, byte_sel};
            default: load_data = 32'h0000_0000;
        endcase
    end

    assign rd = (busy_reg || access_bad) ? 32'h0000_0000 : load_data;

    // Clear sequencer: walks every word once after reset, then stays READY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= INIT;
            init_ptr_reg <= '0;
            busy_reg     <= 1'b1;
        end else begin
            case (state_reg)
                INIT: begin
                    init_ptr_reg <= init_ptr_reg + PTR_ONE;
                    if (init_ptr_reg == PTR_LAST) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= READY;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record of the first fault since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_valid_reg <= 1'b0;
            fault_addr_reg  <= '0;
        end else if (fault && !fault_valid_reg) begin
            fault_valid_reg <= 1'b1;
            fault_addr_reg  <= addr;
        end
    end

    // Memory array write port: zeroes words during the clear, otherwise commits stores.
    always_ff @(posedge clk) begin
        if (busy_reg) begin
            mem[init_ptr_reg] <= 32'h0000_0000;
        end else if (commit) begin
            mem[word_idx] <= merged_word;
        end
    end

    assign busy        = busy_reg;
    assign fault_valid = fault_valid_reg;
    assign fault_addr  = fault_addr_reg;

`ifdef DM_BYTELANE_TRACE_EN
    // Store and fault trace; clear writes are deliberately silent.
    always @(posedge clk) begin
        if (reset && commit) begin
            $display("%d@%h: *%h <= %h", $time, pc, {addr[ADDR_W-1:2], 2'b00}, merged_word);
        end else if (reset && fault) begin
            $display("FAULT @%h %h", pc, addr);
        end
    end
`else
    // pc only feeds the trace, so it is deliberately left unused here.
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Testbench for dm_bytelane with DEPTH_LOG2=4.
// A byte-addressed reference model runs alongside the DUT and is compared
// against it on every falling edge. Directed steps with literal expected
// values run before and after a randomized phase.
module tb_dm_bytelane;
    localparam int DL     = 4;
    localparam int AW     = 32;
    localparam int NBYTES = 4 << DL;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          mem_write;
    logic          mem_read;
    logic [2:0]    op;
    logic [31:0]   pc;
    logic [31:0]   rd;
    logic          busy;
    logic          fault;
    logic          fault_valid;
    logic [AW-1:0] fault_addr;

    always #5 clk = ~clk;

    dm_bytelane #(.DEPTH_LOG2(DL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wd(wd),
        .mem_write(mem_write), .mem_read(mem_read), .op(op), .pc(pc),
        .rd(rd), .busy(busy), .fault(fault),
        .fault_valid(fault_valid), .fault_addr(fault_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // Reference model: byte array, countdown of clear edges, fault record.
    logic [7:0]    m_bytes [NBYTES];
    int            m_clear_left = 0;
    bit            m_fv = 0;
    logic [AW-1:0] m_fa = '0;

    function automatic int op_size(input logic [2:0] o);
        case (o)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_bad(input logic [AW-1:0] a, input logic [2:0] o);
        if (o > 3'd4) return 1'b1;
        if (a >= AW'(NBYTES)) return 1'b1;
        if ((int'(a[1:0]) % op_size(o)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [AW-1:0] a, input logic [2:0] o);
        logic [31:0] v;
        int sz;
        v = 32'h0;
        if (m_clear_left > 0 || m_bad(a, o)) return 32'h0;
        sz = op_size(o);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = m_bytes[int'(a) + i];
        if ((o == 3'd1 || o == 3'd3) && v[8*sz-1])
            for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    // Model state update, mirroring the asynchronous reset of the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear_left <= 1 << DL;
            m_fv         <= 1'b0;
            m_fa         <= '0;
        end else if (m_clear_left > 0) begin
            m_clear_left <= m_clear_left - 1;
            if (m_clear_left == 1)
                for (int i = 0; i < NBYTES; i++) m_bytes[i] <= 8'h00;
        end else begin
            if ((mem_write || mem_read) && m_bad(addr, op) && !m_fv) begin
                m_fv <= 1'b1;
                m_fa <= addr;
            end
            if (mem_write && !m_bad(addr, op))
                for (int i = 0; i < op_size(op); i++) m_bytes[int'(addr) + i] <= wd[8*i +: 8];
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (rd === m_load(addr, op) &&
                busy === (m_clear_left > 0) &&
                fault === ((mem_write || mem_read) && (m_clear_left == 0) && m_bad(addr, op)) &&
                fault_valid === m_fv && fault_addr === m_fa) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_cmp t=%0t addr=%h op=%0d w=%0d r=%0d: got rd=%h busy=%b fault=%b fv=%b fa=%h, want rd=%h busy=%b fault=%b fv=%b fa=%h",
                         $time, addr, op, mem_write, mem_read, rd, busy, fault, fault_valid, fault_addr,
                         m_load(addr, op), (m_clear_left > 0),
                         ((mem_write || mem_read) && (m_clear_left == 0) && m_bad(addr, op)), m_fv, m_fa);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input bit w, input bit r, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_write = w;
        mem_read  = r;
        op        = o;
        addr      = a;
        wd        = d;
        $display("txn t=%0t w=%0d r=%0d op=%0d addr=%h wd=%h", $time, w, r, o, a, d);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (busy) cnt++;
            else break;
        end
        mem_write = 1'b0;
        check(name, 32'(cnt), 32'd16);
    endtask

    task automatic random_phase(input int n);
        logic [2:0]  o;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            o = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 19) == 0) a[31] = 1'b1;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, a, $urandom);
        end
    endtask

    initial begin
        reset     = 1'b0;
        mem_write = 1'b1;
        mem_read  = 1'b0;
        op        = 3'd0;
        addr      = 32'h28;
        wd        = 32'hDEADBEEF;
        pc        = 32'h0000_3018;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b1;

        // Clear sequence length with a store held pending throughout.
        count_busy("busy_edges");
        drive(0, 1, 3'd0, 32'h28, 0); sample(); check("lw_after_clear", rd, 32'h0000_0000);

        // Byte lanes and load extension.
        drive(1, 0, 3'd0, 32'h28, 32'hFFFFFFFF);
        drive(1, 0, 3'd3, 32'h29, 32'h00000012);
        drive(0, 1, 3'd0, 32'h28, 0); sample(); check("lw_28_sb", rd, 32'hFFFF12FF);
        drive(0, 1, 3'd3, 32'h29, 0); sample(); check("lb_29", rd, 32'h00000012);
        drive(0, 1, 3'd3, 32'h2B, 0); sample(); check("lb_2b", rd, 32'hFFFFFFFF);
        drive(0, 1, 3'd4, 32'h2B, 0); sample(); check("lbu_2b", rd, 32'h000000FF);

        // Halfword lanes.
        drive(1, 0, 3'd1, 32'h2A, 32'h00008001);
        drive(0, 1, 3'd1, 32'h2A, 0); sample(); check("lh_2a", rd, 32'hFFFF8001);
        drive(0, 1, 3'd2, 32'h2A, 0); sample(); check("lhu_2a", rd, 32'h00008001);
        drive(0, 1, 3'd0, 32'h28, 0); sample(); check("lw_28_sh", rd, 32'h800112FF);

        // Faults and the sticky record.
        drive(1, 0, 3'd1, 32'h29, 32'h1234); sample(); check("sh_29_fault", 32'(fault), 32'd1);
        drive(0, 1, 3'd0, 32'h28, 0); sample();
        check("lw_28_unchanged", rd, 32'h800112FF);
        check("fault_valid_set", 32'(fault_valid), 32'd1);
        check("fault_addr_first", fault_addr, 32'h29);
        drive(0, 1, 3'd0, 32'h31, 0); sample(); check("lw_31_fault", 32'(fault), 32'd1);
        drive(1, 0, 3'd0, 32'h40, 32'h55555555); sample(); check("sw_40_fault", 32'(fault), 32'd1);
        drive(0, 1, 3'd0, 32'h40, 0); sample();
        check("lw_40_zero", rd, 32'h0000_0000);
        check("fault_addr_kept", fault_addr, 32'h29);

        random_phase(300);

        // Reset pulled low 2 ns before the commit edge of a store.
        drive(1, 0, 3'd0, 32'h28, 32'hAAAAAAAA);
        #7;
        reset = 1'b0;
        #1;
        check("busy_on_reset", 32'(busy), 32'd1);
        check("fv_on_reset", 32'(fault_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        count_busy("busy_edges_2");
        drive(0, 1, 3'd0, 32'h28, 0); sample(); check("lw_after_reset", rd, 32'h0000_0000);

        random_phase(100);
        sample();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
